mac_accum: RTL and testbench
============================

# mac_accum

Sequential multiply-accumulate stage that consumes 4-bit operand pairs, forms each 4x4 unsigned product, and sums a fixed number of products into one accumulated result. It sits directly downstream of the combinational 4x4 multiplier datapath and turns a stream of products into dot-product results. It uses a valid/ready handshake on both input and output.

## Interface
- DATA_W, 4, operand width in bits; the product width is 2*DATA_W.
- COUNT, 4, number of products summed per result; range 1..255.
- ACC_W, 12, accumulator and result width; must be at least 2*DATA_W.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  an operand pair is present.
- in_ready  output  1  the block accepts an operand pair this cycle.
- in1  input  DATA_W  unsigned multiplicand.
- in2  input  DATA_W  unsigned multiplier.
- out_valid  output  1  a result is held on out_sum.
- out_ready  input  1  the downstream stage takes the result.
- out_sum  output  ACC_W  accumulated sum of COUNT products.
- out_ovf  output  1  overflow flag for the current result; sticky across that result's accumulation.

## Operation
- States:
  - ACCUM: accepting operand pairs.
  - HOLD: presenting a result.
- Input handshake:
  - in_ready = (state==ACCUM) && !rst.
  - A beat is accepted when in_valid && in_ready.
- On each accepted beat:
  - The product p = in1*in2 is computed at 2*DATA_W bits and zero-extended to ACC_W+1 bits.
  - acc <= acc + p.
  - cnt <= cnt + 1.
- Overflow: if the (ACC_W+1)-bit sum exceeds 2^ACC_W − 1, ovf is set. ovf stays set until the result is consumed.
- End of a result:
  - The accepted beat with cnt == COUNT−1 completes the result.
  - On that edge: state moves to HOLD, cnt returns to 0, and out_sum/out_ovf take the final values.
- Output handshake:
  - out_valid = (state==HOLD).
  - When out_valid && out_ready: acc and ovf clear to 0 and state returns to ACCUM.
- While in HOLD:
  - No input beats are accepted.
  - out_sum and out_ovf are stable until the output handshake completes.
- in1/in2 are ignored when in_valid is low. X on the operands is permitted when in_valid is low.

## Timing
- Reset (synchronous, rst high at an edge) sets: state=ACCUM, acc=0, cnt=0, ovf=0. Resulting output values:
  - out_valid=0.
  - out_sum=0.
  - out_ovf=0.
  - in_ready=0 while rst is high, 1 in the first cycle after rst falls.
- Reset mid-accumulation or in HOLD discards the partial sum or the held result. No output is produced for it.
- Latency: the last beat is accepted at edge t; out_valid is high in the cycle following edge t.
- Throughput:
  - COUNT input beats per result, one beat per cycle maximum.
  - A minimum of one HOLD cycle per result.
  - With out_ready tied high: COUNT+1 cycles per result.
- in_ready falls in the same cycle out_valid rises. in_ready returns the cycle after the output handshake edge.
- There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- COUNT=1: every accepted beat goes straight to HOLD.

## Configuration
- MAC_SAT_EN defined: on overflow the accumulator clamps to 2^ACC_W − 1 and stays clamped for the remainder of the result. ovf is set.
- MAC_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W. ovf is set on the first wrap.

## Structure
- Shared package mac_pkg holds:
  - The state enum (ACCUM, HOLD).
  - The default width constants DATA_W_DEF=4 and ACC_W_DEF=12.
- Sub-module mul_pp, combinational, produces the unsigned DATA_W×DATA_W product by partial-product AND-and-shift. mac_accum instantiates it once.
- The counter width is $clog2(COUNT+1).

## Test plan
- Reset, then 4 beats (3,5),(2,7),(15,15),(1,1) with out_ready=1 → out_sum=255 one cycle after the 4th beat, out_ovf=0, in_ready low for exactly one cycle.
- in_valid toggling every other cycle across 4 beats (1,1)×4 → out_sum=4. The result appears only after the 4th accepted beat, and gaps do not advance cnt.
- out_ready held low for 5 cycles in HOLD → out_valid and out_sum are stable and in_ready=0 throughout. in_valid pulses during HOLD are ignored; the next result is unaffected.
- COUNT=20 with (15,15)×20:
  - Without MAC_SAT_EN: out_sum=4500 mod 4096=404, out_ovf=1.
  - With MAC_SAT_EN: out_sum=4095, out_ovf=1.
  - On the following result of (1,2)×20: out_sum=40, out_ovf=0.
- rst asserted after 2 of 4 beats, then (2,3)×4 → out_sum=24. The partial sum is discarded.
- COUNT=1 with back-to-back beats (4,4),(0,9) and out_ready=1 → results 16 then 0, one result every 2 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate stage.
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

  localparam int DATA_W_DEF = 4;
  localparam int ACC_W_DEF  = 12;

endpackage

// File: rtl/mac_accum_if.sv
// Operand/result bus of mac_accum. The master drives operands and out_ready;
// the slave (mac_accum) drives in_ready and the result.
interface mac_accum_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  // Both channels use plain valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; valid never waits on ready, and the
  // sender holds its payload stable until that edge.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/mul_pp.sv
// Combinational unsigned DATA_W x DATA_W multiplier built from shifted
// partial products (one AND row per multiplier bit).
module mul_pp
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (b[i]) p = p + ({{DATA_W{1'b0}}, a} << i);
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Multiply-accumulate stage: sums COUNT products per result, then holds it
// until taken. Define MAC_SAT_EN to clamp on overflow instead of wrapping.
module mac_accum
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COUNT  = 4,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mac_accum_if.slave bus,
  output mac_state_e dbg_state
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_nxt;
  logic              beat;

  mul_pp #(.DATA_W(DATA_W)) u_mul (
    .a (bus.in1),
    .b (bus.in2),
    .p (prod)
  );

  assign beat = bus.in_valid && bus.in_ready;
  // One extra bit on the adder catches the carry that marks overflow.
  assign sum  = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};

  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    ovf_nxt = ovf | sum[ACC_W];
`ifdef MAC_SAT_EN
    // Once clamped, stay clamped even if later products are zero.
    if (ovf || sum[ACC_W]) acc_nxt = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (state == ST_ACCUM) begin
      if (beat) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          state <= ST_HOLD;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end else if (bus.out_ready) begin
      acc   <= '0;
      ovf   <= 1'b0;
      state <= ST_ACCUM;
    end
  end

  assign bus.in_ready  = (state == ST_ACCUM) && !rst;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign dbg_state     = mac_state_e'(state);

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three instances (COUNT = 4, 20, 1) checked every cycle
// against a sum-of-products model, plus literal results for directed cases.
module tb_mac_accum;
  import mac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  logic       iv   [3];
  logic [3:0] a    [3];
  logic [3:0] b    [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [11:0] os  [3];
  logic       oovf [3];
  mac_state_e st   [3];
  int         cnt_of [3] = '{4, 20, 1};

  mac_accum_if #(.DATA_W(4), .ACC_W(12)) bus0 ();
  mac_accum_if #(.DATA_W(4), .ACC_W(12)) bus1 ();
  mac_accum_if #(.DATA_W(4), .ACC_W(12)) bus2 ();

  mac_accum #(.DATA_W(4), .COUNT(4),  .ACC_W(12)) u0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(st[0]));
  mac_accum #(.DATA_W(4), .COUNT(20), .ACC_W(12)) u1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(st[1]));
  mac_accum #(.DATA_W(4), .COUNT(1),  .ACC_W(12)) u2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(st[2]));

  assign bus0.in_valid = iv[0]; assign bus0.in1 = a[0]; assign bus0.in2 = b[0]; assign bus0.out_ready = ordy[0];
  assign bus1.in_valid = iv[1]; assign bus1.in1 = a[1]; assign bus1.in2 = b[1]; assign bus1.out_ready = ordy[1];
  assign bus2.in_valid = iv[2]; assign bus2.in1 = a[2]; assign bus2.in2 = b[2]; assign bus2.out_ready = ordy[2];
  assign ir[0] = bus0.in_ready; assign ov[0] = bus0.out_valid; assign os[0] = bus0.out_sum; assign oovf[0] = bus0.out_ovf;
  assign ir[1] = bus1.in_ready; assign ov[1] = bus1.out_valid; assign os[1] = bus1.out_sum; assign oovf[1] = bus1.out_ovf;
  assign ir[2] = bus2.in_ready; assign ov[2] = bus2.out_valid; assign os[2] = bus2.out_sum; assign oovf[2] = bus2.out_ovf;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Result of a completed group of products: {ovf, sum}.
  function automatic logic [12:0] model_res(int s);
    logic [11:0] v;
`ifdef MAC_SAT_EN
    v = (s > 4095) ? 12'd4095 : 12'(s);
`else
    v = 12'(s % 4096);
`endif
    return {s > 4095, v};
  endfunction

  logic [12:0] exp_q [3][$];
  int  part_sum [3] = '{0, 0, 0};
  int  part_n   [3] = '{0, 0, 0};
  bit  checking = 1'b0;
  int  res_seen [3] = '{0, 0, 0};
  int  last_sum [3];
  int  last_ovf [3];
  int  hs_edge  [3];
  int  log2_sum [$];
  int  log2_edge[$];

  // Inputs change just after posedge, so everything here is stable; the
  // update half predicts what the coming posedge will do.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (checking) begin
        check($sformatf("u%0d.in_ready", i), int'(ir[i]), int'(!rst && exp_q[i].size() == 0));
        check($sformatf("u%0d.out_valid", i), int'(ov[i]), int'(exp_q[i].size() != 0));
        check($sformatf("u%0d.dbg_state", i), int'(st[i] == HOLD), int'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          check($sformatf("u%0d.out_sum", i), int'(os[i]), int'(exp_q[i][0][11:0]));
          check($sformatf("u%0d.out_ovf", i), int'(oovf[i]), int'(exp_q[i][0][12]));
        end
        if (!rst && ov[i] && ordy[i]) begin
          res_seen[i]++;
          last_sum[i] = int'(os[i]);
          last_ovf[i] = int'(oovf[i]);
          hs_edge[i]  = cyc + 1;
          if (i == 2) begin
            log2_sum.push_back(int'(os[i]));
            log2_edge.push_back(cyc + 1);
          end
        end
      end
      if (rst) begin
        part_sum[i] = 0;
        part_n[i]   = 0;
        exp_q[i].delete();
      end else if (exp_q[i].size() != 0) begin
        if (ordy[i]) void'(exp_q[i].pop_front());
      end else if (iv[i]) begin
        part_sum[i] += int'(a[i]) * int'(b[i]);
        part_n[i]++;
        if (part_n[i] == cnt_of[i]) begin
          exp_q[i].push_back(model_res(part_sum[i]));
          part_sum[i] = 0;
          part_n[i]   = 0;
        end
      end
    end
    if (rst) checking = 1'b1;
  end

  // ---------------- driver tasks ----------------
  int acc_edge [3];

  // Called just after a posedge; returns just after the posedge that took the beat.
  task automatic send(int i, int x, int y);
    bit r;
    bit done = 1'b0;
    iv[i] = 1'b1; a[i] = 4'(x); b[i] = 4'(y);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      r = ir[i];
      if (r) acc_edge[i] = cyc + 1;
      @(posedge clk); #1;
      done = r;
    end
    if (!done) check($sformatf("u%0d.send_timeout", i), 0, 1);
    iv[i] = 1'b0;
  endtask

  task automatic wait_res(int i, int n0);
    int k = 0;
    while (res_seen[i] <= n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (res_seen[i] <= n0) check($sformatf("u%0d.result_timeout", i), 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  int n0;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; a[i] = '0; b[i] = '0; ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.out_valid", int'(ov[0]), 0);
    check("reset.out_sum", int'(os[0]), 0);
    check("reset.out_ovf", int'(oovf[0]), 0);
    check("reset.in_ready", int'(ir[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready_after", int'(ir[0]), 1);
    @(posedge clk); #1;

    // Mixed operands, out_ready high.
    n0 = res_seen[0];
    send(0, 3, 5); send(0, 2, 7); send(0, 15, 15); send(0, 1, 1);
    wait_res(0, n0);
    check("t1.sum", last_sum[0], 255);
    check("t1.ovf", last_ovf[0], 0);
    check("t1.latency", hs_edge[0] - acc_edge[0], 1);

    // Valid toggling with one idle cycle between beats.
    n0 = res_seen[0];
    for (int k = 0; k < 4; k++) begin
      send(0, 1, 1);
      if (k == 2) check("t2.no_early_result", res_seen[0], n0);
      idle(1);
    end
    wait_res(0, n0);
    check("t2.sum", last_sum[0], 4);

    // Stall in HOLD with valid pulses that must be ignored.
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 1, 2);
    for (int k = 0; k < 5; k++) begin
      iv[0] = (k % 2) == 0; a[0] = 4'd15; b[0] = 4'd15;
      @(negedge clk);
      check("t3.hold_valid", int'(ov[0]), 1);
      check("t3.hold_sum", int'(os[0]), 8);
      check("t3.hold_ready", int'(ir[0]), 0);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    n0 = res_seen[0];
    ordy[0] = 1'b1;
    wait_res(0, n0);
    check("t3.sum", last_sum[0], 8);
    n0 = res_seen[0];
    for (int k = 0; k < 4; k++) send(0, 2, 2);
    wait_res(0, n0);
    check("t3.next_sum", last_sum[0], 16);

    // Reset mid-accumulation discards the partial sum.
    n0 = res_seen[0];
    send(0, 5, 5); send(0, 5, 5);
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 2, 3);
    wait_res(0, n0);
    check("t5.sum", last_sum[0], 24);
    check("t5.one_result", res_seen[0], n0 + 1);

    // COUNT=20 overflow, then a clean result.
    n0 = res_seen[1];
    for (int k = 0; k < 20; k++) send(1, 15, 15);
    wait_res(1, n0);
`ifdef MAC_SAT_EN
    check("t4.sum", last_sum[1], 4095);
`else
    check("t4.sum", last_sum[1], 404);
`endif
    check("t4.ovf", last_ovf[1], 1);
    n0 = res_seen[1];
    for (int k = 0; k < 20; k++) send(1, 1, 2);
    wait_res(1, n0);
    check("t4.next_sum", last_sum[1], 40);
    check("t4.next_ovf", last_ovf[1], 0);

    // COUNT=1 back-to-back.
    n0 = res_seen[2];
    log2_sum.delete(); log2_edge.delete();
    send(2, 4, 4); send(2, 0, 9);
    wait_res(2, n0 + 1);
    if (log2_sum.size() >= 2) begin
      check("t6.first", log2_sum[0], 16);
      check("t6.second", log2_sum[1], 0);
      check("t6.spacing", log2_edge[1] - log2_edge[0], 2);
    end else begin
      check("t6.result_count", log2_sum.size(), 2);
    end

    // Randomised traffic on all instances, with one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = $urandom_range(0, 1) == 1;
        a[i]    = 4'($urandom_range(0, 15));
        b[i]    = 4'($urandom_range(0, 15));
        ordy[i] = $urandom_range(0, 3) != 0;
      end
      rst = (c == 300);
      idle(1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    idle(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
